// File: rtl/latency_window_checker.sv
// latency_window_checker
//
// Multi-channel monitor for the rule "trigger implies response within
// MIN_DLY..MAX_DLY clocks". Every trigger starts an attempt that ages one
// step per clock. An attempt passes on the first in-window response and
// fails when it reaches MAX_DLY without one. Attempts overlap freely.
//
// Parameters
//   NCH      number of independent channels (1..16)
//   MIN_DLY  earliest post-trigger edge at which a response counts (>=1)
//   MAX_DLY  latest post-trigger edge at which a response counts (MIN_DLY..15)
//   CNT_W    width of each saturating pass/fail counter
//
// Ports
//   i_clk         sampling clock, all state changes on posedge
//   i_rst_n       asynchronous active-low reset, zeroes everything
//   i_en          gates the start of new attempts only
//   i_clr         synchronous clear of all state, dominates other inputs
//   i_trig        per-channel antecedent
//   i_resp        per-channel consequent
//   o_pass_pulse  one-cycle pulse: at least one attempt passed at the last edge
//   o_fail_pulse  one-cycle pulse: an attempt expired at the last edge
//   o_err_sticky  set by the first fail, cleared by i_clr or i_rst_n
//   o_pend        channel has at least one outstanding attempt
//   o_pass_cnt    saturating passed-attempt counts, channel c at [c*CNT_W +: CNT_W]
//   o_fail_cnt    saturating failed-attempt counts, same packing
module latency_window_checker #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned MIN_DLY = 1,
    parameter int unsigned MAX_DLY = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic [NCH-1:0]       i_trig,
    input  logic [NCH-1:0]       i_resp,
    output logic [NCH-1:0]       o_pass_pulse,
    output logic [NCH-1:0]       o_fail_pulse,
    output logic [NCH-1:0]       o_err_sticky,
    output logic [NCH-1:0]       o_pend,
    output logic [NCH*CNT_W-1:0] o_pass_cnt,
    output logic [NCH*CNT_W-1:0] o_fail_cnt
);

    // Popcount of the passing set never exceeds MAX_DLY.
    localparam int unsigned PopW = $clog2(MAX_DLY + 1);
    localparam int unsigned SumW = CNT_W + PopW;
    localparam logic [CNT_W-1:0] CntMax = '1;

    // Age vector: bit k set means an attempt started k edges ago.
    logic [MAX_DLY:1] r_age      [NCH];
    logic [CNT_W-1:0] r_pass_cnt [NCH];
    logic [CNT_W-1:0] r_fail_cnt [NCH];
    logic [NCH-1:0]   r_pass_pulse;
    logic [NCH-1:0]   r_fail_pulse;
    logic [NCH-1:0]   r_err;
    logic [NCH-1:0]   r_pend;

    logic [MAX_DLY:1] w_age_d      [NCH];
    logic [MAX_DLY:1] w_pass_mask  [NCH];
    logic [PopW-1:0]  w_pop        [NCH];
    logic [SumW-1:0]  w_pass_sum   [NCH];
    logic [CNT_W-1:0] w_pass_cnt_d [NCH];
    logic [CNT_W-1:0] w_fail_cnt_d [NCH];
    logic [NCH-1:0]   w_pass_any;
    logic [NCH-1:0]   w_fail;
    logic [NCH-1:0]   w_pend_d;
    logic [NCH-1:0]   w_err_d;

    always_comb begin
        for (int c = 0; c < int'(NCH); c++) begin
            // Only ages inside the window can be resolved by a response.
            w_pass_mask[c] = '0;
            for (int k = int'(MIN_DLY); k <= int'(MAX_DLY); k++) begin
                w_pass_mask[c][k] = r_age[c][k] & i_resp[c];
            end
            w_pass_any[c] = |w_pass_mask[c];

            // The oldest attempt either passes now or expires now.
            w_fail[c] = r_age[c][MAX_DLY] & ~i_resp[c];

            // Survivors shift up one age; the oldest slot always leaves.
            w_age_d[c] = '0;
            for (int k = 1; k < int'(MAX_DLY); k++) begin
                w_age_d[c][k+1] = r_age[c][k] & ~w_pass_mask[c][k];
            end
            // A same-edge trigger enters at age 1, unaffected by this resp.
            w_age_d[c][1] = i_en & i_trig[c];
            w_pend_d[c]   = |w_age_d[c];

            w_pop[c] = '0;
            for (int k = 1; k <= int'(MAX_DLY); k++) begin
                w_pop[c] = w_pop[c] + PopW'(w_pass_mask[c][k]);
            end

            w_pass_sum[c]   = SumW'(r_pass_cnt[c]) + SumW'(w_pop[c]);
            w_pass_cnt_d[c] = (w_pass_sum[c] > SumW'(CntMax)) ? CntMax
                                                              : w_pass_sum[c][CNT_W-1:0];
            w_fail_cnt_d[c] = (w_fail[c] && (r_fail_cnt[c] != CntMax))
                              ? r_fail_cnt[c] + 1'b1 : r_fail_cnt[c];
            w_err_d[c]      = r_err[c] | w_fail[c];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < int'(NCH); c++) begin
                r_age[c]      <= '0;
                r_pass_cnt[c] <= '0;
                r_fail_cnt[c] <= '0;
            end
            r_pass_pulse <= '0;
            r_fail_pulse <= '0;
            r_err        <= '0;
            r_pend       <= '0;
        end else if (i_clr) begin
            for (int c = 0; c < int'(NCH); c++) begin
                r_age[c]      <= '0;
                r_pass_cnt[c] <= '0;
                r_fail_cnt[c] <= '0;
            end
            r_pass_pulse <= '0;
            r_fail_pulse <= '0;
            r_err        <= '0;
            r_pend       <= '0;
        end else begin
            for (int c = 0; c < int'(NCH); c++) begin
                r_age[c]      <= w_age_d[c];
                r_pass_cnt[c] <= w_pass_cnt_d[c];
                r_fail_cnt[c] <= w_fail_cnt_d[c];
            end
            r_pass_pulse <= w_pass_any;
            r_fail_pulse <= w_fail;
            r_err        <= w_err_d;
            r_pend       <= w_pend_d;
        end
    end

    assign o_pass_pulse = r_pass_pulse;
    assign o_fail_pulse = r_fail_pulse;
    assign o_err_sticky = r_err;
    assign o_pend       = r_pend;

    always_comb begin
        o_pass_cnt = '0;
        o_fail_cnt = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            o_pass_cnt[c*CNT_W +: CNT_W] = r_pass_cnt[c];
            o_fail_cnt[c*CNT_W +: CNT_W] = r_fail_cnt[c];
        end
    end

endmodule

// File: tb/tb_latency_window_checker.sv
// Self-checking bench for latency_window_checker. A main instance (CNT_W=8)
// and a narrow-counter instance (CNT_W=2) share all inputs. Expected values
// come from a constant vector table, hand-written sequences and a reference
// model that keeps each channel's outstanding attempts as a queue of
// trigger edge numbers.
module tb_latency_window_checker;

    localparam int NCH   = 2;
    localparam int MIND  = 1;
    localparam int MAXD  = 4;
    localparam int CW    = 8;
    localparam int CW2   = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic clr;
    logic [NCH-1:0] trig;
    logic [NCH-1:0] resp;

    logic [NCH-1:0]     pass_pulse, fail_pulse, err_sticky, pend;
    logic [NCH*CW-1:0]  pass_cnt, fail_cnt;
    logic [NCH-1:0]     d2_pass_pulse, d2_fail_pulse, d2_err_sticky, d2_pend;
    logic [NCH*CW2-1:0] d2_pass_cnt, d2_fail_cnt;

    always #5 clk = ~clk;

    latency_window_checker #(
        .NCH(NCH), .MIN_DLY(MIND), .MAX_DLY(MAXD), .CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr),
        .i_trig(trig), .i_resp(resp),
        .o_pass_pulse(pass_pulse), .o_fail_pulse(fail_pulse),
        .o_err_sticky(err_sticky), .o_pend(pend),
        .o_pass_cnt(pass_cnt), .o_fail_cnt(fail_cnt)
    );

    latency_window_checker #(
        .NCH(NCH), .MIN_DLY(MIND), .MAX_DLY(MAXD), .CNT_W(CW2)
    ) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr),
        .i_trig(trig), .i_resp(resp),
        .o_pass_pulse(d2_pass_pulse), .o_fail_pulse(d2_fail_pulse),
        .o_err_sticky(d2_err_sticky), .o_pend(d2_pend),
        .o_pass_cnt(d2_pass_cnt), .o_fail_cnt(d2_fail_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int q [NCH][$];
    int pass_tot [NCH];
    int fail_tot [NCH];
    logic [NCH-1:0] m_pp, m_fp, m_err, m_pend;
    int edge_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            q[c].delete();
            pass_tot[c] = 0;
            fail_tot[c] = 0;
        end
        m_pp = '0; m_fp = '0; m_err = '0; m_pend = '0;
    endtask

    // One clock edge of the rule, from trigger times and ages.
    task automatic model_edge();
        edge_n++;
        if (!rst_n || clr) begin
            model_clear();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            int keep [$];
            int age;
            keep.delete();
            m_pp[c] = 1'b0;
            m_fp[c] = 1'b0;
            for (int i = 0; i < q[c].size(); i++) begin
                age = edge_n - q[c][i];
                if (resp[c] && age >= MIND && age <= MAXD) begin
                    m_pp[c] = 1'b1;
                    pass_tot[c]++;
                end else if (age >= MAXD) begin
                    m_fp[c] = 1'b1;
                    fail_tot[c]++;
                end else begin
                    keep.push_back(q[c][i]);
                end
            end
            q[c] = keep;
            if (en && trig[c]) q[c].push_back(edge_n);
            if (m_fp[c]) m_err[c] = 1'b1;
            m_pend[c] = (q[c].size() != 0);
        end
    endtask

    task automatic compare_model();
        logic [NCH*CW-1:0]  epc, efc;
        logic [NCH*CW2-1:0] epc2, efc2;
        for (int c = 0; c < NCH; c++) begin
            epc[c*CW +: CW]    = (pass_tot[c] > 255) ? 8'd255 : 8'(pass_tot[c]);
            efc[c*CW +: CW]    = (fail_tot[c] > 255) ? 8'd255 : 8'(fail_tot[c]);
            epc2[c*CW2 +: CW2] = (pass_tot[c] > 3) ? 2'd3 : 2'(pass_tot[c]);
            efc2[c*CW2 +: CW2] = (fail_tot[c] > 3) ? 2'd3 : 2'(fail_tot[c]);
        end
        check("model_pass_pulse", 64'(pass_pulse), 64'(m_pp));
        check("model_fail_pulse", 64'(fail_pulse), 64'(m_fp));
        check("model_err_sticky", 64'(err_sticky), 64'(m_err));
        check("model_pend", 64'(pend), 64'(m_pend));
        check("model_pass_cnt", 64'(pass_cnt), 64'(epc));
        check("model_fail_cnt", 64'(fail_cnt), 64'(efc));
        check("model_w2_pass_cnt", 64'(d2_pass_cnt), 64'(epc2));
        check("model_w2_fail_cnt", 64'(d2_fail_cnt), 64'(efc2));
    endtask

    task automatic step(input logic e, input logic c, input logic [NCH-1:0] t,
                        input logic [NCH-1:0] r);
        en = e; clr = c; trig = t; resp = r;
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pass_pulse"}, 64'(pass_pulse), 64'd0);
        check({tag, "_fail_pulse"}, 64'(fail_pulse), 64'd0);
        check({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
        check({tag, "_pend"}, 64'(pend), 64'd0);
        check({tag, "_pass_cnt"}, 64'(pass_cnt), 64'd0);
        check({tag, "_fail_cnt"}, 64'(fail_cnt), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; trig = '0; resp = '0;
        @(posedge clk);
        #1;
        model_clear();
        check_all_zero("reset");
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic           en;
        logic           clr;
        logic [NCH-1:0] trig;
        logic [NCH-1:0] resp;
        logic [NCH-1:0] pp;
        logic [NCH-1:0] fp;
        logic [NCH-1:0] pend;
        logic [CW-1:0]  pc0;
        logic [CW-1:0]  fc1;
        logic [NCH-1:0] err;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // en clr trig resp | pass fail pend pass_cnt0 fail_cnt1 err
        tbl[0]  = '{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 8'd0, 8'd0, 2'b00};
        tbl[1]  = '{1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 8'd1, 8'd0, 2'b00};
        tbl[2]  = '{1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 8'd1, 8'd0, 2'b00};
        tbl[3]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 8'd1, 8'd0, 2'b00};
        tbl[4]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 8'd1, 8'd0, 2'b00};
        tbl[5]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 8'd1, 8'd0, 2'b00};
        tbl[6]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 8'd1, 8'd1, 2'b10};
        tbl[7]  = '{1'b0, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 8'd1, 8'd1, 2'b10};
        tbl[8]  = '{1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00};
        tbl[9]  = '{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 8'd0, 8'd0, 2'b00};
        tbl[10] = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 8'd1, 8'd0, 2'b00};
        tbl[11] = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 8'd1, 8'd0, 2'b00};

        model_clear();
        do_reset();

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].trig, tbl[i].resp);
            check($sformatf("tbl%0d_pass_pulse", i), 64'(pass_pulse), 64'(tbl[i].pp));
            check($sformatf("tbl%0d_fail_pulse", i), 64'(fail_pulse), 64'(tbl[i].fp));
            check($sformatf("tbl%0d_pend", i), 64'(pend), 64'(tbl[i].pend));
            check($sformatf("tbl%0d_pass_cnt0", i), 64'(pass_cnt[7:0]), 64'(tbl[i].pc0));
            check($sformatf("tbl%0d_fail_cnt1", i), 64'(fail_cnt[15:8]), 64'(tbl[i].fc1));
            check($sformatf("tbl%0d_err", i), 64'(err_sticky), 64'(tbl[i].err));
        end

        // Single pass: resp two edges after trig
        do_reset();
        idle(2);
        step(1'b1, 1'b0, 2'b01, 2'b00);
        idle(1);
        step(1'b1, 1'b0, 2'b00, 2'b01);
        check("single_pass_pulse", 64'(pass_pulse), 64'h1);
        check("single_pass_cnt", 64'(pass_cnt), 64'h0001);
        check("single_fail_cnt", 64'(fail_cnt), 64'h0);
        check("single_pend", 64'(pend), 64'h0);
        idle(1);
        check("single_pulse_width", 64'(pass_pulse), 64'h0);

        // Timeout
        do_reset();
        step(1'b1, 1'b0, 2'b01, 2'b00);
        for (int i = 1; i < MAXD; i++) begin
            idle(1);
            check($sformatf("timeout_early%0d", i), 64'(fail_pulse), 64'h0);
        end
        idle(1);
        check("timeout_fail_pulse", 64'(fail_pulse), 64'h1);
        check("timeout_err", 64'(err_sticky), 64'h1);
        check("timeout_fail_cnt", 64'(fail_cnt), 64'h0001);
        check("timeout_pass_cnt", 64'(pass_cnt), 64'h0);
        idle(3);
        check("timeout_err_held", 64'(err_sticky), 64'h1);

        // Overlapping pass: four attempts resolved by one resp
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b01, 2'b00);
        step(1'b1, 1'b0, 2'b00, 2'b01);
        check("ovl_pass_cnt", 64'(pass_cnt), 64'h0004);
        check("ovl_pass_pulse", 64'(pass_pulse), 64'h1);
        check("ovl_no_fail", 64'(fail_pulse), 64'h0);
        check("ovl_pend", 64'(pend), 64'h0);

        // Overlapping fail with en gating the fourth trigger
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b10, 2'b00);
        step(1'b0, 1'b0, 2'b10, 2'b00);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check($sformatf("ovf_fail%0d", i), 64'(fail_pulse), 64'h2);
        end
        check("ovf_fail_cnt1", 64'(fail_cnt[15:8]), 64'd3);
        idle(1);
        check("ovf_no_4th_fail", 64'(fail_pulse), 64'h0);
        check("ovf_ch0_cnts", 64'({pass_cnt[7:0], fail_cnt[7:0]}), 64'h0);

        // Asynchronous reset mid-operation
        do_reset();
        step(1'b1, 1'b0, 2'b01, 2'b00);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async");
        model_clear();
        idle(1);
        rst_n = 1'b1;
        idle(1);
        idle(1);
        check("async_no_fail", 64'(fail_pulse), 64'h0);

        // Synchronous clear mid-operation
        do_reset();
        step(1'b1, 1'b0, 2'b01, 2'b00);
        idle(1);
        step(1'b1, 1'b1, 2'b11, 2'b11);
        check_all_zero("clr");
        idle(1);
        idle(1);
        check("clr_no_fail", 64'(fail_pulse), 64'h0);

        // Saturation on the narrow-counter instance
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, (i < 5) ? 2'b01 : 2'b00, 2'b00);
            if (i >= 4)
                check($sformatf("sat_fail_cnt_%0d", i - 3), 64'(d2_fail_cnt[1:0]),
                      64'((i - 3 > 3) ? 3 : i - 3));
        end
        check("sat_err", 64'(d2_err_sticky), 64'h1);
        check("sat_wide_fail_cnt", 64'(fail_cnt[7:0]), 64'd5);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [NCH-1:0] t, r;
            for (int c = 0; c < NCH; c++) begin
                t[c] = ($urandom_range(0, 2) != 0);
                r[c] = ($urandom_range(0, 3) == 0);
            end
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 199) == 0), t, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/latency_window_checker.md
# latency_window_checker

Synthesizable multi-channel monitor for the bounded-latency rule "trigger implies response within MIN_DLY to MAX_DLY clocks". It tracks every overlapping attempt per channel, pulses pass/fail per attempt, and keeps saturating pass/fail counters and a sticky error flag. It sits beside the design under test, or in silicon debug logic. Firmware and benches read its results without relying on simulator-only concurrent assertions.

## Interface
- NCH, 2: number of independent channels (1..16)
- MIN_DLY, 1: earliest edge after trigger at which a response counts (>=1)
- MAX_DLY, 4: latest edge after trigger at which a response counts (MIN_DLY..15)
- CNT_W, 8: width of each pass/fail counter

- clk  in  1  sampling clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  when low, no new attempts start; pending attempts keep evaluating
- clr  in  1  synchronous clear of all state; dominates every other input
- trig  in  NCH  per-channel antecedent
- resp  in  NCH  per-channel consequent
- pass_pulse  out  NCH  one-cycle pulse; at least one attempt passed at the last edge
- fail_pulse  out  NCH  one-cycle pulse; an attempt expired at the last edge
- err_sticky  out  NCH  set by the first fail; cleared only by clr or rst_n
- pend  out  NCH  channel has at least one outstanding attempt
- pass_cnt  out  NCH*CNT_W  per-channel saturating count of passed attempts (channel i at [i*CNT_W +: CNT_W])
- fail_cnt  out  NCH*CNT_W  per-channel saturating count of failed attempts

## Operation
- Each channel has a MAX_DLY-bit age vector p[1..MAX_DLY]. p[k]=1 means an attempt started k edges ago.
- At each posedge, per channel, the following are evaluated in one step using pre-edge values:
  - Passing set: all k in [MIN_DLY, MAX_DLY] with p[k]=1 and resp=1. These attempts are removed.
  - Failing attempt: p[MAX_DLY]=1 and resp=0. This attempt is removed. At most one fail per channel per edge.
  - Aging: surviving p[k] move to p[k+1]. Bits with k < MIN_DLY are never resolved by resp.
  - New attempt: p[1] is loaded with en & trig.
- A trig and a resp sampled at the same edge:
  - resp resolves only the older attempts.
  - The new attempt begins at age 1 on the following edge.
- pass_cnt adds the popcount of the passing set, between 0 and MAX_DLY-MIN_DLY+1. It saturates at 2^CNT_W-1 and does not wrap.
- fail_cnt adds 0 or 1 and saturates the same way.
- pass_pulse is 1 iff the passing set is non-empty. fail_pulse is 1 iff a fail occurred. Both can be 1 in the same cycle.
- err_sticky is set with fail_pulse.
- pend is registered: it is the OR of the next-state age vector.
- Channels are fully independent. No cross-channel arbitration.
- clr=1 at a posedge zeroes the age vectors, pulses, sticky flags and counters. trig/resp at that edge are ignored.
- rst_n low immediately drives every output and every internal register to 0, regardless of clk.
- Once rst_n is released, the first posedge with rst_n high samples normally.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Pass latency:
  - trig sampled at edge t, first resp at edge t+k (MIN_DLY<=k<=MAX_DLY).
  - pass_pulse and the counter update are visible after edge t+k, for exactly one cycle.
- Fail latency: with no resp in t+MIN_DLY..t+MAX_DLY, fail_pulse is visible after edge t+MAX_DLY.
- A resp outside the window (before t+MIN_DLY, or after a fail) has no effect on that attempt.
- pend rises after edge t. It falls after the edge that resolves the last outstanding attempt.
- No throughput limit: trig may be asserted every cycle indefinitely.

## Test plan
- Single pass (MIN=1, MAX=4, CNT_W=8, NCH=2):
  - Stimulus: trig[0] at edge 10 only; resp[0] at edge 12 only.
  - Required: pass_pulse[0]=1 for the cycle after edge 12; pass_cnt0=1; fail_cnt0=0; pend[0]=0 after edge 12; channel 1 unchanged.
- Timeout:
  - Stimulus: trig[0] at edge 10; resp[0]=0 throughout.
  - Required: fail_pulse[0] only after edge 14; err_sticky[0]=1 from then on; fail_cnt0=1; pass_cnt0=0.
- Overlapping pass:
  - Stimulus: trig[0] held for edges 10..13; resp[0] at edge 14 only.
  - Required: one pass_pulse after edge 14; pass_cnt0 jumps 0 to 4 in a single cycle; no fail.
- Overlapping fail plus en gating:
  - Stimulus: trig[1] held for edges 10..12 with en=1, then trig[1]=1 at edge 13 with en=0; resp=0 throughout.
  - Required: fail_pulse[1] after edges 14, 15, 16; fail_cnt1=3; no fail after edge 17; channel 0 counters stay 0.
- Reset and clear mid-operation:
  - Stimulus: trig[0] at edge 10; rst_n low between edges 11 and 12, released before edge 13.
  - Required: all outputs 0 immediately; no fail_pulse at edge 14.
  - Repeat with clr=1 at edge 12. Required: same result, with the outputs clearing at edge 12.
- Saturation:
  - Stimulus: CNT_W=2; trig[0] held for 5 consecutive edges with no resp.
  - Required: fail_cnt0 reads 1, 2, 3, 3, 3 after the five fail edges; err_sticky[0]=1.
